// File: rtl/pipe_hazard_scoreboard_if.sv
// rtl/pipe_hazard_scoreboard_if.sv - ID-stage / hazard-scoreboard signal bundle
//
// master: the ID/EXE pipeline control (drives the decoded instruction, flush
//         and the forwarding mode; consumes hazard, operand selects, counters).
// slave : the scoreboard itself.
interface pipe_hazard_scoreboard_if #(
    parameter int REG_W = 4,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
);
    localparam int SEL_W = $clog2(DEPTH);

    logic             forwarding_en;
    logic             id_valid;
    logic             id_wb_en;
    logic             id_mem_r_en;
    logic             id_two_src;
    logic [REG_W-1:0] id_dest;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             flush;
    logic             hazard;
    logic [SEL_W-1:0] sel_src1;
    logic [SEL_W-1:0] sel_src2;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output forwarding_en, id_valid, id_wb_en, id_mem_r_en, id_two_src,
               id_dest, id_src1, id_src2, flush,
        input  hazard, sel_src1, sel_src2, stall_cnt, flush_cnt
    );

    modport slave (
        input  forwarding_en, id_valid, id_wb_en, id_mem_r_en, id_two_src,
               id_dest, id_src1, id_src2, flush,
        output hazard, sel_src1, sel_src2, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - in-flight register scoreboard with stall and forwarding select
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (clears all slots and counters)
//   bus  - pipe_hazard_scoreboard_if.slave:
//          forwarding_en, id_* (ID instruction), flush in;
//          hazard (combinational freeze), sel_src1/2 (EXE operand source,
//          0 = register file, n = slot n+1), stall_cnt/flush_cnt out.
//
// Slot 1 is EXE, slot DEPTH is WB. Slot DEPTH never stalls ID because the
// register file writes through in that cycle.
module pipe_hazard_scoreboard #(
    parameter int REG_W      = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 3,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    pipe_hazard_scoreboard_if.slave bus
);
    localparam int SEL_W = $clog2(DEPTH);

    logic [DEPTH:1]   s_valid;
    logic [DEPTH:1]   s_wb_en;
    logic [DEPTH:1]   s_load;
    logic [REG_W-1:0] s_dest [1:DEPTH];
    logic [REG_W-1:0] s1_src1;
    logic [REG_W-1:0] s1_src2;
    logic             s1_two_src;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic             hz1;
    logic             hz2;
    logic             hazard;
    logic [SEL_W-1:0] sel1;
    logic [SEL_W-1:0] sel2;

    function automatic logic slot_match(input int k, input logic [REG_W-1:0] s);
        return s_valid[k] && s_wb_en[k] && (s_dest[k] == s);
    endfunction

    // Hazard detection against the ID instruction's sources.
    always_comb begin
        hz1 = 1'b0;
        hz2 = 1'b0;
        if (!bus.forwarding_en) begin
            for (int k = 1; k < DEPTH; k++) begin
                if (slot_match(k, bus.id_src1)) hz1 = 1'b1;
                if (slot_match(k, bus.id_src2)) hz2 = 1'b1;
            end
        end else begin
            // Descending scan so the youngest matching slot decides.
            for (int k = DEPTH; k >= 1; k--) begin
                if (slot_match(k, bus.id_src1)) hz1 = s_load[k] && (k + 1 < LOAD_STAGE);
                if (slot_match(k, bus.id_src2)) hz2 = s_load[k] && (k + 1 < LOAD_STAGE);
            end
        end
        hazard = bus.id_valid && (hz1 || (bus.id_two_src && hz2));
    end

    // Operand select for the instruction currently in EXE (slot 1).
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int j = DEPTH; j >= 2; j--) begin
            if (slot_match(j, s1_src1) && (!s_load[j] || j >= LOAD_STAGE))
                sel1 = SEL_W'(j - 1);
            if (slot_match(j, s1_src2) && (!s_load[j] || j >= LOAD_STAGE))
                sel2 = SEL_W'(j - 1);
        end
        if (!s_valid[1] || !bus.forwarding_en) begin
            sel1 = '0;
            sel2 = '0;
        end
        if (!s1_two_src) sel2 = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid    <= '0;
            s_wb_en    <= '0;
            s_load     <= '0;
            for (int k = 1; k <= DEPTH; k++) s_dest[k] <= '0;
            s1_src1    <= '0;
            s1_src2    <= '0;
            s1_two_src <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                s_valid[k] <= s_valid[k-1];
                s_wb_en[k] <= s_wb_en[k-1];
                s_load[k]  <= s_load[k-1];
                s_dest[k]  <= s_dest[k-1];
            end
            // Flush outranks hazard: either way EXE receives a bubble.
            s_valid[1] <= bus.id_valid && !hazard && !bus.flush;
            s_wb_en[1] <= bus.id_wb_en;
            s_load[1]  <= bus.id_mem_r_en;
            s_dest[1]  <= bus.id_dest;
            s1_src1    <= bus.id_src1;
            s1_src2    <= bus.id_src2;
            s1_two_src <= bus.id_two_src;

            if (hazard && !bus.flush && !(&stall_q)) stall_q <= stall_q + 1'b1;
            if (bus.flush && !(&flush_q))            flush_q <= flush_q + 1'b1;
        end
    end

    assign bus.hazard    = hazard;
    assign bus.sel_src1  = sel1;
    assign bus.sel_src2  = sel2;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb/tb_pipe_hazard_scoreboard.sv - directed-vector bench for pipe_hazard_scoreboard
module tb_pipe_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fwd = 1'b0;
    logic       flush = 1'b0;
    logic       id_valid = 1'b0;
    logic       id_wb_en = 1'b0;
    logic       id_mem_r_en = 1'b0;
    logic       id_two_src = 1'b0;
    logic [3:0] id_dest = '0;
    logic [3:0] id_src1 = '0;
    logic [3:0] id_src2 = '0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard_if #(.REG_W(4), .DEPTH(3), .CNT_W(16)) bus ();
    pipe_hazard_scoreboard_if #(.REG_W(4), .DEPTH(3), .CNT_W(4))  bus_s ();

    assign bus.forwarding_en   = fwd;
    assign bus.flush           = flush;
    assign bus.id_valid        = id_valid;
    assign bus.id_wb_en        = id_wb_en;
    assign bus.id_mem_r_en     = id_mem_r_en;
    assign bus.id_two_src      = id_two_src;
    assign bus.id_dest         = id_dest;
    assign bus.id_src1         = id_src1;
    assign bus.id_src2         = id_src2;
    assign bus_s.forwarding_en = fwd;
    assign bus_s.flush         = flush;
    assign bus_s.id_valid      = id_valid;
    assign bus_s.id_wb_en      = id_wb_en;
    assign bus_s.id_mem_r_en   = id_mem_r_en;
    assign bus_s.id_two_src    = id_two_src;
    assign bus_s.id_dest       = id_dest;
    assign bus_s.id_src1       = id_src1;
    assign bus_s.id_src2       = id_src2;

    pipe_hazard_scoreboard #(.REG_W(4), .DEPTH(3), .LOAD_STAGE(3), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_hazard_scoreboard #(.REG_W(4), .DEPTH(3), .LOAD_STAGE(3), .CNT_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    task automatic expect_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic wb, input logic ld, input logic two,
                            input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
        id_valid    = v;
        id_wb_en    = wb;
        id_mem_r_en = ld;
        id_two_src  = two;
        id_dest     = d;
        id_src1     = s1;
        id_src2     = s2;
        #1;
    endtask

    task automatic drain();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        #1;
        expect_eq("rst_hazard", int'(bus.hazard), 0);
        expect_eq("rst_sel1", int'(bus.sel_src1), 0);
        expect_eq("rst_sel2", int'(bus.sel_src2), 0);
        expect_eq("rst_stall", int'(bus.stall_cnt), 0);
        expect_eq("rst_flush", int'(bus.flush_cnt), 0);

        // Forwarding on: ALU r1 then two readers of r1
        fwd = 1'b1;
        drive_id(1, 1, 0, 0, 1, 0, 0);
        expect_eq("fwd_alu_prod_hz", int'(bus.hazard), 0);
        tick();
        drive_id(1, 1, 0, 0, 4, 1, 0);
        expect_eq("fwd_alu_cons_hz", int'(bus.hazard), 0);
        tick();
        expect_eq("fwd_alu_sel1_1", int'(bus.sel_src1), 1);
        expect_eq("fwd_alu_sel2_0", int'(bus.sel_src2), 0);
        drive_id(1, 1, 0, 0, 5, 1, 0);
        expect_eq("fwd_alu_cons2_hz", int'(bus.hazard), 0);
        tick();
        expect_eq("fwd_alu_sel1_2", int'(bus.sel_src1), 2);
        drain();

        // Forwarding off: same dependency stalls two cycles
        fwd = 1'b0;
        drive_id(1, 1, 0, 0, 1, 0, 0);
        expect_eq("nofwd_prod_hz", int'(bus.hazard), 0);
        tick();
        drive_id(1, 1, 0, 0, 6, 1, 0);
        expect_eq("nofwd_hz_c1", int'(bus.hazard), 1);
        tick();
        expect_eq("nofwd_hz_c2", int'(bus.hazard), 1);
        tick();
        expect_eq("nofwd_hz_c3", int'(bus.hazard), 0);
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        expect_eq("nofwd_sel1", int'(bus.sel_src1), 0);
        expect_eq("nofwd_stall", int'(bus.stall_cnt), 2);
        drain();

        // Forwarding on: load r2, consumer reads r2 as src2
        fwd = 1'b1;
        drive_id(1, 1, 1, 0, 2, 0, 0);
        tick();
        drive_id(1, 1, 0, 1, 8, 7, 2);
        expect_eq("ld_use_hz_c1", int'(bus.hazard), 1);
        tick();
        expect_eq("ld_use_hz_c2", int'(bus.hazard), 0);
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        expect_eq("ld_use_sel2", int'(bus.sel_src2), 2);
        expect_eq("ld_use_sel1", int'(bus.sel_src1), 0);
        expect_eq("ld_use_stall", int'(bus.stall_cnt), 3);
        drain();

        // Flush against a load-use hazard: flush wins
        drive_id(1, 1, 1, 0, 3, 0, 0);
        tick();
        flush = 1'b1;
        drive_id(1, 1, 0, 0, 9, 3, 0);
        expect_eq("flush_hz_comb", int'(bus.hazard), 1);
        tick();
        flush = 1'b0;
        fwd   = 1'b0;
        drive_id(1, 1, 0, 0, 10, 9, 0);
        expect_eq("flush_bubble", int'(bus.hazard), 0);
        expect_eq("flush_stall", int'(bus.stall_cnt), 3);
        expect_eq("flush_cnt", int'(bus.flush_cnt), 1);
        tick();
        drain();

        // Reset mid-stall with all slots full
        drive_id(1, 1, 0, 0, 1, 0, 0);
        tick();
        drive_id(1, 1, 0, 0, 2, 0, 0);
        tick();
        drive_id(1, 1, 0, 0, 3, 0, 0);
        tick();
        drive_id(1, 1, 0, 0, 11, 3, 0);
        expect_eq("midstall_hz", int'(bus.hazard), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        expect_eq("postrst_hazard", int'(bus.hazard), 0);
        expect_eq("postrst_sel1", int'(bus.sel_src1), 0);
        expect_eq("postrst_sel2", int'(bus.sel_src2), 0);
        expect_eq("postrst_stall", int'(bus.stall_cnt), 0);
        expect_eq("postrst_flush", int'(bus.flush_cnt), 0);
        drain();

        // 20 stall cycles: 4-bit counter saturates at 15
        for (int r = 0; r < 10; r++) begin
            drive_id(1, 1, 0, 0, 1, 0, 0);
            tick();
            drive_id(1, 1, 0, 0, 15, 1, 0);
            expect_eq("sat_hz_a", int'(bus_s.hazard), 1);
            tick();
            expect_eq("sat_hz_b", int'(bus_s.hazard), 1);
            tick();
            expect_eq("sat_hz_c", int'(bus_s.hazard), 0);
            tick();
            if (r == 6) expect_eq("sat_stall_14", int'(bus_s.stall_cnt), 14);
        end
        drive_id(0, 0, 0, 0, 0, 0, 0);
        expect_eq("sat_stall_15", int'(bus_s.stall_cnt), 15);
        expect_eq("wide_stall_20", int'(bus.stall_cnt), 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_scoreboard.md
PIPE_HAZARD_SCOREBOARD -- requirements
Module: pipe_hazard_scoreboard

Interface
REQ-001 SHALL provide parameter REG_W, default 4, register-tag width.
REQ-002 SHALL provide parameter DEPTH, default 3, legal range 2..8, in-flight slots from EXE (slot 1) to WB (slot DEPTH).
REQ-003 SHALL provide parameter LOAD_STAGE, default 3, legal range 2..DEPTH, first slot at which load data is forwardable.
REQ-004 SHALL provide parameter CNT_W, default 16, statistics counter width.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port forwarding_en  in  1  enables forwarding mode.
REQ-007 SHALL have ports id_valid, id_wb_en, id_mem_r_en, id_two_src  in  1 each  ID-stage valid, writes register, is load, uses src2.
REQ-008 SHALL have ports id_dest, id_src1, id_src2  in  REG_W each  ID-stage tags.
REQ-009 SHALL have port flush  in  1  branch taken in EXE; kills the ID instruction.
REQ-010 SHALL have port hazard  out  1  ID must freeze this cycle (combinational).
REQ-011 SHALL have ports sel_src1, sel_src2  out  SEL_W=clog2(DEPTH) each  EXE operand source: 0 = register file, n = slot n+1.
REQ-012 SHALL have ports stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-013 SHALL hold DEPTH slots, each {valid, wb_en, is_load, dest}; slot 1 additionally holds {src1, src2, two_src}.
REQ-014 Each rising edge SHALL shift slot k to k+1 (k<DEPTH) and discard slot DEPTH.
REQ-015 Slot 1 SHALL load the ID instruction when id_valid && !hazard && !flush; otherwise it SHALL load a bubble (valid=0).
REQ-016 A slot k matches source s when valid && wb_en && dest==s; src2 is checked only when id_two_src=1; src1 is always checked.
REQ-017 hazard SHALL be 0 whenever id_valid=0.
REQ-018 With forwarding_en=0, hazard SHALL be 1 if any slot k<DEPTH matches an ID source; slot DEPTH never causes a hazard, since the register file writes through.
REQ-019 With forwarding_en=1, hazard SHALL be 1 only if the youngest matching slot k (smallest k) has is_load=1 and k+1<LOAD_STAGE.
REQ-020 sel_srcN SHALL equal j-1, where j is the smallest slot in 2..DEPTH matching slot 1's srcN with (is_load=0 or j>=LOAD_STAGE).
REQ-021 sel_srcN SHALL be 0 when there is no match, when slot 1 is invalid, when forwarding_en=0, or, for src2, when slot 1 two_src=0.
REQ-022 stall_cnt SHALL increment by 1 per cycle with hazard && !flush, and SHALL saturate at all-ones.
REQ-023 flush_cnt SHALL increment by 1 per cycle with flush=1, and SHALL saturate at all-ones.
REQ-024 When flush and hazard are both 1, flush SHALL win: slot 1 gets a bubble and stall_cnt is unchanged.
REQ-025 A forwarding_en change SHALL take effect in the same cycle, with no pipeline drain.

Reset
REQ-026 With rst=1 at a clock edge, all slots SHALL become invalid and both counters SHALL become 0, overriding all other inputs including mid-stall or mid-flush.
REQ-027 After reset, hazard=0 and sel_src1=sel_src2=0 SHALL hold until a valid instruction enters slot 1.

Verification (DEPTH=3, LOAD_STAGE=3)
REQ-028 Fwd on: ALU writes r1, next ID reads r1 -> hazard=0; next cycle sel_src1=1; following cycle sel_src1=2.
REQ-029 Fwd off: same sequence -> hazard=1 for exactly 2 cycles; consumer enters slot 1 with sel_src1=0; stall_cnt=2.
REQ-030 Fwd on: load writes r2, next ID reads r2 as src2 (two_src=1) -> hazard=1 for 1 cycle; consumer then enters with sel_src2=2; stall_cnt=1.
REQ-031 Load r3 in slot 1 with flush=1 and ID reading r3 -> slot 1 bubble next cycle; stall_cnt unchanged; flush_cnt +1.
REQ-032 rst=1 pulsed mid-stall with slots full -> next cycle hazard=0, all sel=0, counters=0.
REQ-033 CNT_W=4: 20 consecutive hazard cycles -> stall_cnt holds at 15 with no wrap.
